// File: rtl/cond_sequencer_if.sv
// Execute-stage bundle between the issue side and cond_sequencer.
// COND_PERF_EN adds the SquashCount/BranchCount performance counters.
interface cond_sequencer_if;
  logic       InstValid;
  logic       InstReady;
  logic       Hold;
  logic [1:0] Cond;
  logic [1:0] FlagsWrite;
  logic [3:0] ALUFlags;
  logic       RegWriteIn;
  logic       MemWriteIn;
  logic       BranchIn;
  logic       OutValid;
  logic       CondEx;
  logic       RegWriteOut;
  logic       MemWriteOut;
  logic       PCSrc;
  logic [3:0] Flags;
  logic       Flush;
`ifdef COND_PERF_EN
  logic [15:0] SquashCount;
  logic [15:0] BranchCount;
`endif

  modport master (
`ifdef COND_PERF_EN
    input  SquashCount, BranchCount,
`endif
    output InstValid, Hold, Cond, FlagsWrite, ALUFlags,
    output RegWriteIn, MemWriteIn, BranchIn,
    input  InstReady, OutValid, CondEx, RegWriteOut, MemWriteOut,
    input  PCSrc, Flags, Flush
  );

  modport slave (
`ifdef COND_PERF_EN
    output SquashCount, BranchCount,
`endif
    input  InstValid, Hold, Cond, FlagsWrite, ALUFlags,
    input  RegWriteIn, MemWriteIn, BranchIn,
    output InstReady, OutValid, CondEx, RegWriteOut, MemWriteOut,
    output PCSrc, Flags, Flush
  );
endinterface

// File: rtl/cond_sequencer.sv
// Conditional-execution sequencer: NZCV flags, condition gating and branch flush.
// Optional performance counters are enabled by defining COND_PERF_EN.
module cond_sequencer #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  cond_sequencer_if.slave  bus
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam bit         FLUSH_EN   = (FLUSH_CYCLES > 0);

  logic [0:0] r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_flags;
  logic       r_outValid;
  logic       r_condEx;
  logic       r_regWrite;
  logic       r_memWrite;
  logic       r_pcSrc;

  logic       w_accept;
  logic       w_condTrue;
  logic       w_exec;
  logic       w_taken;

  assign w_accept = bus.InstValid & ~bus.Hold;

  // Conditions look only at the committed flags, never at this instruction's ALUFlags.
  always_comb begin
    w_condTrue = 1'b1;
    case (bus.Cond)
      2'b00:   w_condTrue = 1'b1;
      2'b01:   w_condTrue = r_flags[2];
      2'b10:   w_condTrue = ~r_flags[2];
      default: w_condTrue = r_flags[3] ^ r_flags[0];
    endcase
  end

  assign w_exec  = w_accept & (r_state == ST_RUN) & w_condTrue;
  assign w_taken = w_exec & bus.BranchIn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else if (!bus.Hold) begin
      if (r_state == ST_RUN) begin
        if (w_taken && FLUSH_EN) begin
          r_state <= ST_FLUSH;
          r_cnt   <= FLUSH_LOAD;
        end
      end else begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          r_state <= ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (w_exec) begin
      if (bus.FlagsWrite[1]) r_flags[3:2] <= bus.ALUFlags[3:2];
      if (bus.FlagsWrite[0]) r_flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  // Held cycles have no accept, so every registered output falls to 0 on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_condEx   <= 1'b0;
      r_regWrite <= 1'b0;
      r_memWrite <= 1'b0;
      r_pcSrc    <= 1'b0;
    end else begin
      r_outValid <= w_accept;
      r_condEx   <= w_exec;
      r_regWrite <= w_exec & bus.RegWriteIn;
      r_memWrite <= w_exec & bus.MemWriteIn;
      r_pcSrc    <= w_taken;
    end
  end

  assign bus.InstReady   = ~bus.Hold;
  assign bus.OutValid    = r_outValid;
  assign bus.CondEx      = r_condEx;
  assign bus.RegWriteOut = r_regWrite;
  assign bus.MemWriteOut = r_memWrite;
  assign bus.PCSrc       = r_pcSrc;
  assign bus.Flags       = r_flags;
  assign bus.Flush       = (r_state == ST_FLUSH);

`ifdef COND_PERF_EN
  logic [15:0] r_squashCount;
  logic [15:0] r_branchCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_squashCount <= 16'd0;
      r_branchCount <= 16'd0;
    end else begin
      if (w_accept && !w_exec && r_squashCount != 16'hFFFF)
        r_squashCount <= r_squashCount + 16'd1;
      if (w_taken && r_branchCount != 16'hFFFF)
        r_branchCount <= r_branchCount + 16'd1;
    end
  end

  assign bus.SquashCount = r_squashCount;
  assign bus.BranchCount = r_branchCount;
`endif

endmodule

// File: tb/tb_cond_sequencer.sv
// Directed, table-driven bench for cond_sequencer with FLUSH_CYCLES=2.
// Also checks the COND_PERF_EN counters when that macro is defined.
module tb_cond_sequencer;

  localparam logic [1:0] AL = 2'b00, EQ = 2'b01, NE = 2'b10, LT = 2'b11;

  typedef struct packed {
    logic       v;
    logic       h;
    logic [1:0] cond;
    logic [1:0] fw;
    logic [3:0] alu;
    logic       rw;
    logic       mw;
    logic       br;
    logic [4:0] eCtl;    // {OutValid, CondEx, RegWriteOut, MemWriteOut, PCSrc}
    logic [3:0] eFlags;
    logic       eFlush;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[21];

  cond_sequencer_if bus();

  cond_sequencer #(.FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic h, logic [1:0] cond, logic [1:0] fw,
                              logic [3:0] alu, logic rw, logic mw, logic br,
                              logic [4:0] eCtl, logic [3:0] eFlags, logic eFlush);
    vec_t t;
    t.v = v; t.h = h; t.cond = cond; t.fw = fw; t.alu = alu;
    t.rw = rw; t.mw = mw; t.br = br;
    t.eCtl = eCtl; t.eFlags = eFlags; t.eFlush = eFlush;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t t);
    bus.InstValid  = t.v;
    bus.Hold       = t.h;
    bus.Cond       = t.cond;
    bus.FlagsWrite = t.fw;
    bus.ALUFlags   = t.alu;
    bus.RegWriteIn = t.rw;
    bus.MemWriteIn = t.mw;
    bus.BranchIn   = t.br;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [9:0] outWord();
    return {bus.OutValid, bus.CondEx, bus.RegWriteOut, bus.MemWriteOut,
            bus.PCSrc, bus.Flags, bus.Flush};
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = mk(1,0,AL,2'b11,4'b1100,0,0,0, 5'b11000,4'b1100,0);
    vecs[1]  = mk(1,0,AL,2'b11,4'b0100,0,0,0, 5'b11000,4'b0100,0);
    vecs[2]  = mk(1,0,EQ,2'b01,4'b0011,1,0,0, 5'b11100,4'b0111,0);
    vecs[3]  = mk(1,0,AL,2'b11,4'b0000,0,0,0, 5'b11000,4'b0000,0);
    vecs[4]  = mk(1,0,EQ,2'b11,4'b1111,0,1,0, 5'b10000,4'b0000,0);
    vecs[5]  = mk(0,0,AL,2'b11,4'b1111,1,1,1, 5'b00000,4'b0000,0);
    vecs[6]  = mk(1,0,NE,2'b10,4'b1000,0,1,0, 5'b11010,4'b1000,0);
    vecs[7]  = mk(1,0,LT,2'b01,4'b0001,1,0,0, 5'b11100,4'b1001,0);
    vecs[8]  = mk(1,0,LT,2'b11,4'b0000,1,0,1, 5'b10000,4'b1001,0);
    vecs[9]  = mk(1,1,AL,2'b11,4'b0000,1,1,1, 5'b00000,4'b1001,0);
    vecs[10] = mk(1,0,AL,2'b00,4'b0000,0,0,1, 5'b11001,4'b1001,1);
    vecs[11] = mk(1,0,AL,2'b11,4'b0000,1,0,0, 5'b10000,4'b1001,1);
    vecs[12] = mk(1,0,AL,2'b11,4'b0000,1,0,0, 5'b10000,4'b1001,0);
    vecs[13] = mk(1,0,AL,2'b11,4'b0000,1,0,0, 5'b11100,4'b0000,0);
    vecs[14] = mk(1,0,AL,2'b00,4'b0000,0,0,1, 5'b11001,4'b0000,1);
    vecs[15] = mk(1,1,AL,2'b00,4'b0000,1,0,0, 5'b00000,4'b0000,1);
    vecs[16] = mk(1,1,AL,2'b00,4'b0000,1,0,0, 5'b00000,4'b0000,1);
    vecs[17] = mk(1,1,AL,2'b00,4'b0000,1,0,0, 5'b00000,4'b0000,1);
    vecs[18] = mk(1,0,AL,2'b00,4'b0000,1,0,1, 5'b10000,4'b0000,1);
    vecs[19] = mk(1,0,AL,2'b00,4'b0000,1,0,0, 5'b10000,4'b0000,0);
    vecs[20] = mk(1,0,AL,2'b00,4'b0000,1,0,0, 5'b11100,4'b0000,0);

    rst_n = 1'b0;
    applyStimulus(mk(0,0,AL,2'b00,4'b0000,0,0,0, 5'b0,4'b0,0));
    #3;
    checkOutput("reset_outputs", 16'(outWord()), 16'h0000);
    checkOutput("reset_ready", 16'(bus.InstReady), 16'h0001);
    bus.Hold = 1'b1;
    #1;
    checkOutput("reset_ready_hold", 16'(bus.InstReady), 16'h0000);
    bus.Hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("ready_v%0d", i), 16'(bus.InstReady), 16'(!vecs[i].h));
      @(posedge clk);
      #1;
      checkOutput($sformatf("out_v%0d", i), 16'(outWord()),
                  16'({vecs[i].eCtl, vecs[i].eFlags, vecs[i].eFlush}));
    end

`ifdef COND_PERF_EN
    checkOutput("squash_count", bus.SquashCount, 16'd6);
    checkOutput("branch_count", bus.BranchCount, 16'd2);
`endif

    // Reset pulse in the middle of a flush window.
    applyStimulus(mk(1,0,AL,2'b11,4'b1010,0,0,1, 5'b0,4'b0,0));
    @(posedge clk);
    #1;
    checkOutput("midflush_enter", 16'({bus.PCSrc, bus.Flags, bus.Flush}), 16'b1_1010_1);
    applyStimulus(mk(0,0,AL,2'b00,4'b0000,0,0,0, 5'b0,4'b0,0));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midflush_reset", 16'(outWord()), 16'h0000);
`ifdef COND_PERF_EN
    checkOutput("branch_count_reset", bus.BranchCount, 16'd0);
    checkOutput("squash_count_reset", bus.SquashCount, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(1,0,AL,2'b00,4'b0000,1,0,0, 5'b0,4'b0,0));
    @(posedge clk);
    #1;
    checkOutput("post_reset_exec", 16'({bus.OutValid, bus.CondEx, bus.RegWriteOut, bus.Flush}),
                16'b1110);
    applyStimulus(mk(0,0,AL,2'b00,4'b0000,0,0,0, 5'b0,4'b0,0));
    @(posedge clk);
    #1;
    checkOutput("idle_after", 16'(outWord()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_sequencer.md
# cond_sequencer

Conditional-execution sequencer for the CPU execute stage. It holds the architectural NZCV flags register and evaluates each accepted instruction's condition code against it. It gates the instruction's register, memory and branch side effects, updates flags under FlagsWrite, and runs a flush state machine that squashes wrong-path instructions after a taken branch.

## Interface
- FLUSH_CYCLES, 2, cycles squashed after a taken branch (0..15; 0 disables flush)
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- InstValid  in  1  execute-stage instruction present
- InstReady  out  1  combinational, equals ~Hold; accept = InstValid & InstReady
- Hold  in  1  downstream stall; freezes all state
- Cond  in  2  00 AL, 01 EQ, 10 NE, 11 LT
- FlagsWrite  in  2  bit1 writes N,Z; bit0 writes C,V
- ALUFlags  in  4  {N,Z,C,V} produced by this instruction
- RegWriteIn, MemWriteIn, BranchIn  in  1 each  ungated control bits
- OutValid  out  1  registered; one-cycle pulse per accepted instruction
- CondEx  out  1  registered condition result, forced 0 when squashed
- RegWriteOut, MemWriteOut, PCSrc  out  1 each  registered, gated control bits
- Flags  out  4  architectural flags register {N,Z,C,V}
- Flush  out  1  1 while state is FLUSH

## Operation
- States: RUN, FLUSH. Reset enters RUN.
- Condition uses the Flags register value before the edge, never ALUFlags: AL=1, EQ=Z, NE=~Z, LT=N^V.
- Accept in RUN with condition true:
  - Flags[3:2] <= ALUFlags[3:2] if FlagsWrite[1].
  - Flags[1:0] <= ALUFlags[1:0] if FlagsWrite[0].
  - Gated outputs = input bits.
- Accept in RUN with condition false: Flags unchanged; RegWriteOut, MemWriteOut and PCSrc are 0; OutValid is 1 and CondEx is 0.
- Taken branch: accept in RUN with condition true and BranchIn=1. If FLUSH_CYCLES>0, go to FLUSH and load cnt=FLUSH_CYCLES.
- FLUSH:
  - InstReady still follows ~Hold.
  - Every accepted instruction is squashed: OutValid=1, CondEx=0, all gated outputs 0, Flags unchanged. A BranchIn on a squashed instruction is ignored.
  - cnt decrements each cycle with Hold=0. The cycle in which cnt reaches 0 returns to RUN; the instruction accepted in that cycle is still squashed.
  - Exactly FLUSH_CYCLES non-held cycles are squashed.
- Hold=1: no accept, and state, cnt and Flags are frozen. OutValid, CondEx and the gated outputs drop to 0 on the next edge.
- Cycles with no accept (InstValid=0) in RUN: OutValid=0, outputs 0, Flags unchanged.

## Timing
- Reset (async assert, sync-safe deassert): Flags=0000, state RUN, cnt=0, OutValid=CondEx=RegWriteOut=MemWriteOut=PCSrc=Flush=0. InstReady follows ~Hold even during reset.
- Latency is 1 cycle: an instruction accepted at edge k drives OutValid, CondEx and the gated outputs during cycle k+1. Flags are updated at edge k.
- Back-to-back accepts: instruction k+1 evaluates against the flags written by instruction k, so no bubble is required.
- Flush rises in the cycle after the taken-branch edge, together with PCSrc=1.
- Reset asserted mid-FLUSH: the flush aborts immediately and the block returns to RUN with the reset values above.

## Configuration
- COND_PERF_EN defined adds two 16-bit outputs:
  - SquashCount counts instructions accepted in FLUSH or with a false condition.
  - BranchCount counts taken branches.
  - Both are zeroed by reset and saturate at 16'hFFFF.
- COND_PERF_EN undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Reset, then AL accept with ALUFlags=1100 and FlagsWrite=11 -> next cycle OutValid=1, CondEx=1, Flags=1100.
- Flags=0100, EQ accept with RegWriteIn=1, ALUFlags=0011, FlagsWrite=01 -> CondEx=1, RegWriteOut=1, Flags=0111.
- Flags=0000, EQ accept with MemWriteIn=1 and FlagsWrite=11 -> CondEx=0, MemWriteOut=0, Flags stay 0000.
- FLUSH_CYCLES=2, AL branch accepted, then 3 back-to-back accepts with RegWriteIn=1:
  - PCSrc=1, then Flush=1 for 2 cycles.
  - The first 2 follow-on instructions are squashed (RegWriteOut=0); the 3rd has RegWriteOut=1.
- Taken branch, then Hold=1 for 3 cycles, then release -> Flush stays 1 across the hold and still squashes exactly 2 non-held cycles.
- rst_n pulsed low mid-FLUSH -> Flush=0 and Flags=0000 immediately; the next AL accept is not squashed. With COND_PERF_EN, BranchCount=0 after the reset.
